// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the add/shift multiply sequencer: ALU opcodes,
// default datapath width and the sequencer state encoding.
package mul_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [3:0] ALU_OP_ADD = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB = 4'b0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_sequencer.sv
// Iterative add/shift multiplier (MUL / MLA) that borrows an external shared
// ALU for its additions; one multiplier bit is retired per ITER cycle.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             n_flag,
  output logic             z_flag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(ITERS) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITERS - 1);

  state_e           state_r;
  state_e           state_next_s;
  logic [WIDTH-1:0] prod_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] result_r;
  logic             n_flag_r;
  logic             z_flag_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;

  // A start coinciding with the done pulse belongs to the finished operation and is dropped.
  assign accept_s = start & ~done_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: fixed ITERS-cycle iteration, no early exit
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = ITER;
        end else begin
          state_next_s = IDLE;
        end
      end
      ITER: begin
        if (count_r == LAST_COUNT) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ITER;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // ALU drive: always prod + mcand; the sum is only consumed in ITER
  always_comb begin
    alu_a   = prod_r;
    alu_b   = mcand_r;
    alu_op  = ALU_OP_ADD;
    alu_cin = 1'b0;
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_r   <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      n_flag_r <= 1'b0;
      z_flag_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ITER);
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r  <= op_a;
            mplier_r <= op_b;
            prod_r   <= accumulate ? acc_in : {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
          end
        end
        ITER: begin
          if (mplier_r[0]) begin
            prod_r <= alu_result;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CW'(1);
        end
        DONE: begin
          result_r <= prod_r;
          n_flag_r <= prod_r[WIDTH-1];
          z_flag_r <= (prod_r == {WIDTH{1'b0}});
        end
        default: begin
          count_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign n_flag = n_flag_r;
  assign z_flag = z_flag_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed and random MUL/MLA operations
// checked against a plain-arithmetic reference, with a behavioural shared ALU.
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         accumulate;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] acc_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         n_flag;
  logic         z_flag;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_op;
  logic         alu_cin;
  logic [W-1:0] alu_result;

  int checks = 0;
  int errors = 0;

  mul_sequencer #(.WIDTH(W), .ITERS(W)) dut (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .op_a(op_a), .op_b(op_b), .acc_in(acc_in),
    .busy(busy), .done(done), .result(result), .n_flag(n_flag), .z_flag(z_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result)
  );

  // Shared ALU stand-in
  always_comb begin
    case (alu_op)
      ALU_OP_ADD: alu_result = alu_a + alu_b + {{(W-1){1'b0}}, alu_cin};
      ALU_OP_SUB: alu_result = alu_a - alu_b;
      default:    alu_result = {W{1'b0}};
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, optionally pulse start again at edge count poke_at,
  // then verify latency, result, flags and that nothing else completes.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic acc, input int poke_at);
    logic [W-1:0] exp;
    logic [63:0]  full;
    int edges;
    int extra;
    logic seen;
    full = 64'(a) * 64'(b) + (acc ? 64'(c) : 64'd0);
    exp  = full[W-1:0];
    @(negedge clk);
    op_a = a; op_b = b; acc_in = c; accumulate = acc; start = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      if (edges > 0) begin
        edges++;
      end else begin
        edges = 1;
      end
      @(negedge clk);
      start = (edges == poke_at);
      if (start) begin
        op_a = 32'h0000_1234; op_b = 32'h0000_0099; acc_in = 32'h0; accumulate = 1'b0;
      end
      if (edges == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(edges - 1), 64'd33);
    check({tag, "_result"}, 64'(result), 64'(exp));
    check({tag, "_n"}, 64'(n_flag), 64'(exp[W-1]));
    check({tag, "_z"}, 64'(z_flag), 64'(exp == 32'd0));
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_no_extra_done"}, 64'(extra), 64'd0);
    check({tag, "_hold"}, 64'(result), 64'(exp));
  endtask

  initial begin
    int extra;
    reset = 1'b1; start = 1'b0; accumulate = 1'b0;
    op_a = 32'h0; op_b = 32'h0; acc_in = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   64'(busy),    64'd0);
    check("rst_done",   64'(done),    64'd0);
    check("rst_result", 64'(result),  64'd0);
    check("rst_n",      64'(n_flag),  64'd0);
    check("rst_z",      64'(z_flag),  64'd0);
    check("rst_alu_a",  64'(alu_a),   64'd0);
    check("rst_alu_b",  64'(alu_b),   64'd0);
    check("rst_alu_op", 64'(alu_op),  64'd0);
    check("rst_cin",    64'(alu_cin), 64'd0);
    reset = 1'b0;

    run_op("mul_7x6",    32'd7,          32'd6,          32'd0, 1'b0, -1);
    run_op("mul_ffxff",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 1'b0, -1);
    run_op("mul_ovf0",   32'h0001_0000,  32'h0001_0000,  32'd0, 1'b0, -1);
    run_op("mul_neg",    32'hFFFF_FFFE,  32'd3,          32'd0, 1'b0, -1);
    run_op("mla_ign",    32'd3,          32'd4,          32'd5, 1'b1, 10);
    run_op("mla_ign_dn", 32'd9,          32'd9,          32'd1, 1'b1, 32);

    // Reset in the 10th ITER cycle: operation discarded, no done
    @(negedge clk);
    op_a = 32'd123; op_b = 32'd456; acc_in = 32'd0; accumulate = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy",   64'(busy),   64'd0);
    check("midrst_done",   64'(done),   64'd0);
    check("midrst_result", 64'(result), 64'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midrst_no_done", 64'(extra), 64'd0);
    run_op("mul_2x2", 32'd2, 32'd2, 32'd0, 1'b0, -1);

    for (int k = 0; k < 8; k++) begin
      run_op($sformatf("rand%0d", k), 32'($urandom), 32'($urandom), 32'($urandom),
             1'($urandom_range(1, 0)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ITERS, default 32, number of add/shift iterations; ITERS equals WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a multiply; sampled only in IDLE.
REQ-006 accumulate  input  1  sampled with start; 1 selects MLA (a*b+acc_in), 0 selects MUL (a*b).
REQ-007 op_a  input  WIDTH  multiplicand, sampled with start.
REQ-008 op_b  input  WIDTH  multiplier, sampled with start.
REQ-009 acc_in  input  WIDTH  accumulate addend, sampled with start.
REQ-010 busy  output  1  high from the cycle after start is accepted through the last ITER cycle.
REQ-011 done  output  1  one-cycle pulse; result and flags are valid.
REQ-012 result  output  WIDTH  low WIDTH bits of the product or sum.
REQ-013 n_flag, z_flag  output  1 each  N = result[WIDTH-1]; Z = (result == 0).
REQ-014 alu_a, alu_b  output  WIDTH each  operands driven to the shared ALU.
REQ-015 alu_op  output  4  ALU opcode; always ALU_OP_ADD (4'b0000).
REQ-016 alu_cin  output  1  ALU carry-in; always 0.
REQ-017 alu_result  input  WIDTH  ALU sum, combinational in the same cycle; ALU C/V/N/Z outputs are not used.

Function
REQ-018 SHALL implement the states IDLE, ITER and DONE.
REQ-019 IDLE: start=1 latches mcand<=op_a, mplier<=op_b, prod<=(accumulate ? acc_in : 0) and count<=0, then moves to ITER; start=0 stays in IDLE.
REQ-020 ITER: alu_a=prod and alu_b=mcand; if mplier[0]=1 then prod<=alu_result, else prod is unchanged.
REQ-021 ITER, every cycle: mcand<=mcand<<1, mplier<=mplier>>1 (logical), count<=count+1.
REQ-022 ITER lasts exactly ITERS cycles regardless of operand values; there is no early termination.
REQ-023 After the ITER cycle with count=ITERS-1, SHALL move to DONE.
REQ-024 DONE lasts one cycle: done=1, result<=prod, flags updated; then unconditionally moves to IDLE.
REQ-025 Latency: start sampled at edge t, done high during the cycle following edge t+ITERS+1 (33 edges for WIDTH=32).
REQ-026 Arithmetic is modulo 2^WIDTH; overflow is discarded silently; signed and unsigned low-half results are identical.
REQ-027 start while busy or done is ignored; the inputs are not re-sampled.
REQ-028 result, n_flag and z_flag hold their values from the last DONE until the next DONE.
REQ-029 In IDLE and DONE, alu_a and alu_b SHALL still reflect prod and mcand; the ALU output is ignored.
REQ-030 busy is low in IDLE and DONE.

Reset
REQ-031 reset=1 at any clock edge forces IDLE, including mid-ITER; the pending operation is discarded and done is not pulsed.
REQ-032 Reset values: busy=0, done=0, result=0, n_flag=0, z_flag=0, prod=0, mcand=0, mplier=0, count=0; alu_op=ALU_OP_ADD and alu_cin=0 constantly.
REQ-033 reset has priority over start in the same cycle.

Structure
REQ-034 A shared package SHALL hold: the ALU opcode constants (ALU_OP_ADD=4'b0000, ALU_OP_SUB=4'b0010), the WIDTH default, and the state encoding (IDLE, ITER, DONE).
REQ-035 No sub-module; the ALU stays external and is connected through the alu_* ports so it can be shared with the main datapath.
REQ-036 count SHALL be $clog2(ITERS)+1 bits wide.

Verification
REQ-037 Bench SHALL instantiate the existing ALU and connect the alu_* ports.
REQ-038 MUL 7*6, accumulate=0 -> done 33 edges after start, result=42, N=0, Z=0.
REQ-039 MUL 0xFFFFFFFF*0xFFFFFFFF -> result=0x00000001, N=0, Z=0.
REQ-040 MUL 0x00010000*0x00010000 -> result=0, Z=1; MUL 0xFFFFFFFE*3 -> result=0xFFFFFFFA, N=1.
REQ-041 MLA 3*4+5 -> result=17; then start pulsed during ITER -> ignored, result stays 17 and no extra done.
REQ-042 reset asserted at the 10th ITER cycle -> busy=0 next edge, no done, result=0; a new MUL 2*2 afterwards -> 4.
